// File: rtl/voltage_bcd_converter.sv
// voltage_bcd_converter
//   Converts a 12-bit averaged ADC code to a 4-digit BCD millivolt reading.
//   A registered multiply by SCALE_NUM (divided by 4096) produces millivolts.
//   A 14-step shift-add-3 (double dabble) FSM then produces the BCD digits.
//   A one-deep pending register holds one sample that arrives mid-conversion.
//
//   Parameter:
//     SCALE_NUM  full-scale reference in mV (1..10000, keeps result <= 9999)
//   Build option:
//     VOLTAGE_ROUNDING_EN  defined -> mv = (prod + 2048) >> 12 (round half-up)
//                          undefined -> mv = prod >> 12 (truncate)
//   Ports:
//     clk        system clock, rising edge
//     reset_n    asynchronous active-low reset
//     avg_in     averaged ADC code
//     avg_valid  one-cycle strobe, avg_in is new
//     bcd_out    {thousands, hundreds, tens, ones}, held between updates
//     bcd_valid  one-cycle pulse when bcd_out updates
//     busy       high whenever the FSM is not IDLE
//     overrun    one-cycle pulse when an unconsumed pending sample is replaced

// One BCD digit's add-3 correction, applied before each left shift.
module bcd_add3_digit (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module voltage_bcd_converter #(
  parameter int SCALE_NUM = 5000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] avg_in,
  input  logic        avg_valid,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  output logic        busy,
  output logic        overrun
);

  localparam int IN_W   = 12;
  localparam int MV_W   = 14;
  localparam int PROD_W = 26;
  localparam int NDIG   = 4;
  localparam int SR_W   = 4*NDIG + MV_W;
  localparam logic [MV_W-1:0] SCALE_K    = MV_W'(SCALE_NUM);
  localparam logic [3:0]      LAST_SHIFT = 4'(MV_W - 1);

  typedef enum logic [1:0] {IDLE, SCALE, SHIFT, DONE} state_t;

  state_t            state;
  logic [IN_W-1:0]   work;
  logic [IN_W-1:0]   pend;
  logic              pend_v;
  logic [SR_W-1:0]   sreg;
  logic [3:0]        cnt;

  // Scale: 12x14 unsigned multiply, then divide by 4096.
  logic [PROD_W-1:0] prod;
  logic [MV_W-1:0]   mv;

  assign prod = PROD_W'(work) * PROD_W'(SCALE_K);

`ifdef VOLTAGE_ROUNDING_EN
  logic [PROD_W:0] prod_r;
  assign prod_r = {1'b0, prod} + (PROD_W+1)'(2048);
  assign mv     = MV_W'(prod_r >> 12);
`else
  assign mv     = MV_W'(prod >> 12);
`endif

  // Double-dabble step: correct each BCD digit, then shift the whole
  // register left by one. The binary part sits in the low MV_W bits.
  logic [NDIG-1:0][3:0] dig_adj;
  logic [SR_W-1:0]      sreg_adj;
  logic [SR_W-1:0]      sreg_nx;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_add3_digit u_dig (
      .din  (sreg[MV_W + 4*g +: 4]),
      .dout (dig_adj[g])
    );
  end

  assign sreg_adj = {dig_adj, sreg[MV_W-1:0]};
  assign sreg_nx  = sreg_adj << 1;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      work      <= '0;
      pend      <= '0;
      pend_v    <= 1'b0;
      sreg      <= '0;
      cnt       <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      overrun   <= 1'b0;

      case (state)
        IDLE: begin
          if (avg_valid) begin
            work  <= avg_in;
            state <= SCALE;
          end
        end

        SCALE: begin
          sreg  <= {{(4*NDIG){1'b0}}, mv};
          cnt   <= '0;
          state <= SHIFT;
        end

        SHIFT: begin
          sreg <= sreg_nx;
          cnt  <= cnt + 4'd1;
          if (cnt == LAST_SHIFT) begin
            bcd_out   <= sreg_nx[SR_W-1 -: 4*NDIG];
            bcd_valid <= 1'b1;
            state     <= DONE;
          end
        end

        DONE: begin
          if (pend_v) begin
            // A strobe landing here while pending is full supersedes the
            // pending sample: the newest value is converted next.
            pend_v <= 1'b0;
            state  <= SCALE;
            if (avg_valid) begin
              work    <= avg_in;
              overrun <= 1'b1;
            end else begin
              work <= pend;
            end
          end else if (avg_valid) begin
            work  <= avg_in;
            state <= SCALE;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // Mid-conversion strobes park in pending; overwriting a full
      // pending slot is reported one cycle later.
      if (avg_valid && (state == SCALE || state == SHIFT)) begin
        pend    <= avg_in;
        pend_v  <= 1'b1;
        overrun <= pend_v;
      end
    end
  end

  // SCALE_NUM <= 10000 guarantees a four-digit result.
  a_mv_range: assert property (@(posedge clk) disable iff (!reset_n)
    (state == SCALE) |-> (mv <= 14'd9999));

endmodule

// File: tb/tb_voltage_bcd_converter.sv
module tb_voltage_bcd_converter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] in_a = '0, in_b = '0;
  logic        val_a = 1'b0, val_b = 1'b0;
  logic [15:0] bcd_a, bcd_b;
  logic        bv_a, bv_b, busy_a, busy_b, ov_a, ov_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  voltage_bcd_converter dut (
    .clk(clk), .reset_n(reset_n), .avg_in(in_a), .avg_valid(val_a),
    .bcd_out(bcd_a), .bcd_valid(bv_a), .busy(busy_a), .overrun(ov_a)
  );

  voltage_bcd_converter #(.SCALE_NUM(10000)) dut10k (
    .clk(clk), .reset_n(reset_n), .avg_in(in_b), .avg_valid(val_b),
    .bcd_out(bcd_b), .bcd_valid(bv_b), .busy(busy_b), .overrun(ov_b)
  );

  // Reference: integer millivolts, then decimal digits by division.
  function automatic logic [15:0] ref_bcd(input int code, input int scale);
    int p, mv;
    p = code * scale;
`ifdef VOLTAGE_ROUNDING_EN
    p = p + 2048;
`endif
    mv = p / 4096;
    return {4'(mv / 1000), 4'((mv / 100) % 10), 4'((mv / 10) % 10), 4'(mv % 10)};
  endfunction

  // Strobe dut A; returns at the falling edge just after the capturing edge.
  task automatic pulse_a(input logic [11:0] v);
    @(negedge clk); in_a = v; val_a = 1'b1;
    @(negedge clk); val_a = 1'b0;
  endtask

  // Cycles from capture until bcd_valid is seen on dut A, -1 on timeout.
  task automatic wait_a(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (bv_a) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    int nv;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bcd_a !== 16'h0000 || bv_a !== 1'b0 || busy_a !== 1'b0 || ov_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: bcd=%h valid=%b busy=%b ovr=%b want 0000/0/0/0", bcd_a, bv_a, busy_a, ov_a);
    end
    reset_n = 1'b1;
    nv = 0;
    repeat (50) begin
      @(negedge clk);
      if (bv_a || busy_a) nv++;
    end
    checks++;
    if (nv !== 0 || bcd_a !== 16'h0000) begin
      errors++;
      $display("FAIL idle_quiet: active_cycles=%0d bcd=%h want 0 and 0000", nv, bcd_a);
    end
  endtask

  task automatic test_latency();
    int lat;
    pulse_a(12'd2048);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL busy_rise: got %b want 1", busy_a);
    end
    wait_a(lat);
    checks++;
    if (lat !== 15) begin
      errors++; $display("FAIL latency_2048: got %0d want 15", lat);
    end
    checks++;
    if (bcd_a !== 16'h2500) begin
      errors++; $display("FAIL value_2048: got %h want 2500", bcd_a);
    end
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || bv_a !== 1'b0 || bcd_a !== 16'h2500) begin
      errors++;
      $display("FAIL after_done: busy=%b valid=%b bcd=%h want 0/0/2500", busy_a, bv_a, bcd_a);
    end
  endtask

  task automatic test_values();
    logic [11:0] codes [4] = '{12'd4095, 12'd0, 12'd819, 12'd1};
`ifdef VOLTAGE_ROUNDING_EN
    logic [15:0] exps [4] = '{16'h4999, 16'h0000, 16'h1000, 16'h0001};
`else
    logic [15:0] exps [4] = '{16'h4998, 16'h0000, 16'h0999, 16'h0001};
`endif
    int lat;
    for (int k = 0; k < 4; k++) begin
      pulse_a(codes[k]);
      wait_a(lat);
      checks++;
      if (lat !== 15 || bcd_a !== exps[k]) begin
        errors++;
        $display("FAIL value_%0d: got %h lat %0d want %h lat 15", codes[k], bcd_a, lat, exps[k]);
      end
    end
  endtask

  task automatic test_back_to_back(input bit third);
    logic [15:0] got [4];
    int at [4];
    int n, ov;
    logic [15:0] exp2;
    exp2 = third ? 16'h0366 : 16'h0244;
    n = 0; ov = 0;
    repeat (20) @(negedge clk);
    for (int c = 0; c <= 45; c++) begin
      @(negedge clk);
      if (bv_a) begin
        if (n < 4) begin got[n] = bcd_a; at[n] = c; end
        n++;
      end
      if (ov_a) ov++;
      val_a = (c == 0) || (c == 5) || (third && c == 8);
      in_a  = (c == 0) ? 12'd100 : (c == 5) ? 12'd200 : 12'd300;
    end
    val_a = 1'b0;
    checks++;
    if (n !== 2) begin
      errors++; $display("FAIL b2b_count(third=%0d): got %0d results want 2", third, n);
    end else begin
      checks++;
      if (got[0] !== 16'h0122 || got[1] !== exp2) begin
        errors++;
        $display("FAIL b2b_values(third=%0d): got %h %h want 0122 %h", third, got[0], got[1], exp2);
      end
      checks++;
      if (at[1] - at[0] !== 16) begin
        errors++; $display("FAIL b2b_spacing(third=%0d): got %0d want 16", third, at[1] - at[0]);
      end
    end
    checks++;
    if (ov !== (third ? 1 : 0)) begin
      errors++; $display("FAIL b2b_overrun(third=%0d): got %0d pulses want %0d", third, ov, third ? 1 : 0);
    end
  endtask

  task automatic test_reset_mid();
    int nv;
    pulse_a(12'd2048);
    repeat (3) @(negedge clk);
    pulse_a(12'd100);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bcd_a !== 16'h0000 || bv_a !== 1'b0 || busy_a !== 1'b0 || ov_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: bcd=%h valid=%b busy=%b ovr=%b want 0000/0/0/0", bcd_a, bv_a, busy_a, ov_a);
    end
    @(negedge clk); reset_n = 1'b1;
    nv = 0;
    repeat (40) begin
      @(negedge clk);
      if (bv_a || busy_a) nv++;
    end
    checks++;
    if (nv !== 0) begin
      errors++; $display("FAIL reset_mid_discard: active_cycles=%0d want 0", nv);
    end
  endtask

  task automatic test_full_scale_sweep();
    logic [11:0] code;
    logic [15:0] exp;
    int lat;
    for (int k = 0; k < 41; k++) begin
      code = (k == 0) ? 12'd4095 : 12'($urandom_range(0, 4095));
      exp  = ref_bcd(int'(code), 10000);
      @(negedge clk); in_b = code; val_b = 1'b1;
      @(negedge clk); val_b = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (bv_b) begin lat = i; break; end
      end
      checks++;
      if (lat !== 15 || bcd_b !== exp) begin
        errors++;
        $display("FAIL sweep10k_%0d: got %h lat %0d want %h lat 15", code, bcd_b, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_values();
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_reset_mid();
    test_full_scale_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voltage_bcd_converter.md
# voltage_bcd_converter

- Converts each 12-bit averaged ADC code into a 4-digit BCD millivolt reading.
- Sits directly downstream of the 256-sample averager: the averager's `Q` feeds `avg_in`, and `bcd_out` feeds the seven-segment display drivers.
- Conversion is a registered scale-multiply followed by a sequential 14-step shift-add-3 (double dabble) FSM.
- A one-deep pending register absorbs a new sample that arrives during a conversion.

## Interface
Parameters:
- `SCALE_NUM`, default 5000: full-scale reference in mV. Range 1..10000, so the result never exceeds 9999.

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `avg_in` in 12: averaged ADC code.
- `avg_valid` in 1: one-cycle strobe marking `avg_in` as new.
- `bcd_out` out 16: {thousands, hundreds, tens, ones} BCD millivolts, held between updates.
- `bcd_valid` out 1: one-cycle pulse when `bcd_out` updates.
- `busy` out 1: high whenever state ≠ IDLE.
- `overrun` out 1: one-cycle pulse when an unconsumed pending sample is overwritten.

## Operation
States:
- IDLE: on `avg_valid`, latch `avg_in` into the working register, then go to SCALE.
- SCALE:
  - prod[25:0] = avg_in × SCALE_NUM.
  - mv[13:0] = prod >> 12 (see Configuration for rounding).
  - Load shift register {bcd[15:0]=0, mv}, clear shift count, go to SHIFT.
- SHIFT:
  - Each cycle: for each BCD nibble ≥ 5 add 3, then shift the whole register left by 1.
  - After the 14th shift, load `bcd_out` and go to DONE.
- DONE:
  - `bcd_valid` = 1 for this cycle.
  - If pending is valid: move pending into the working register, clear pending, go to SCALE.
  - Else if `avg_valid` is high: take `avg_in` directly, go to SCALE.
  - Else go to IDLE.

Pending register:
- `avg_valid` in SCALE or SHIFT writes `avg_in` into pending and sets pending-valid.
- If pending-valid was already set, the new value overwrites the old one and `overrun` pulses on the next cycle.
- `avg_valid` in DONE while pending-valid is set:
  - The new value replaces pending.
  - `overrun` pulses.
  - The replaced (new) value is converted next.
- Data is never dropped silently except through an `overrun` pulse.

Arithmetic:
- All values are unsigned.
- The multiply is 12×14 → 26 bits.
- mv is at most 9999 for every legal `SCALE_NUM`. No saturation logic is required, but an assertion checks mv ≤ 9999.

## Timing
- Reset values:
  - `bcd_out` = 16'h0000; `bcd_valid`, `busy`, `overrun` = 0.
  - State IDLE; pending and working registers cleared.
- Reset asserted mid-conversion aborts immediately. Nothing is output and the pending sample is discarded.
- Latency: with `avg_valid` captured at edge 0, SCALE runs at edge 1 and shifts at edges 2–15. `bcd_out` and `bcd_valid` are visible after edge 15, i.e. 15 cycles.
- `busy` rises after edge 0 and falls after edge 16 when no work is pending.
- Throughput: one conversion per 16 cycles with back-to-back samples (DONE → SCALE skips IDLE).
- `bcd_out` is stable outside the update edge. It changes only together with `bcd_valid`.

## Configuration
- `VOLTAGE_ROUNDING_EN` defined: mv = (prod + 2048) >> 12, i.e. round half-up.
- Not defined: mv = prod >> 12, i.e. truncation.
- Latency is identical in both builds.

## Test plan
- Reset then idle: `bcd_out`=0000, `busy`=0, no `bcd_valid` for 50 cycles. Assert `reset_n` low mid-SHIFT: all outputs return to reset values at once.
- `avg_in`=2048, SCALE_NUM=5000 → `bcd_out`=16'h2500 exactly 15 cycles after the strobe, in both builds.
- `avg_in`=4095 → 16'h4998 truncated, 16'h4999 with `VOLTAGE_ROUNDING_EN`. `avg_in`=0 → 16'h0000.
- `avg_in`=819 → 16'h0999 truncated, 16'h1000 rounded (BCD carry across all digits). `avg_in`=1 → 16'h0001 in both builds.
- Back-to-back samples:
  - Strobe 100 at cycle 0 and 200 at cycle 5 → results 16'h0122 then 16'h0244 (truncated), 16 cycles apart, no `overrun`.
  - Add a third strobe (300) at cycle 8 → `overrun` pulses once, and 300 (16'h0366) replaces 200.
- SCALE_NUM=10000, `avg_in`=4095 → 16'h9997 truncated / 16'h9998 rounded; the mv ≤ 9999 assertion never fires on a full random 0..4095 sweep checked against a reference model.
